// File: rtl/sensor_sweep_scheduler.sv
// sensor_sweep_scheduler: periodic round-robin sharing of one ADC between
// NUM_CH sensor channels. Each sweep walks the enabled channels in ascending
// order, issues a req/ack conversion per channel, publishes each sample, and
// refreshes the LED "below threshold" status bits.
module sensor_sweep_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 12,
    parameter int PERIOD  = 1000,
    parameter int TIMEOUT = 64,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [DATA_W-1:0] thresh,
    output logic              adc_req,
    output logic [CH_W-1:0]   adc_ch,
    input  logic              adc_ack,
    input  logic [DATA_W-1:0] adc_data,
    output logic              result_valid,
    output logic [CH_W-1:0]   result_ch,
    output logic [DATA_W-1:0] result_data,
    output logic [NUM_CH-1:0] LED,
    output logic [NUM_CH-1:0] timeout_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // One extra bit so cur can hold NUM_CH, meaning "past the last channel".
    localparam int CUR_W = CH_W + 1;

    typedef enum logic [1:0] {IDLE, SELECT, REQ, PUBLISH} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic              tick;
    logic [CUR_W-1:0]  cur;
    logic [TMR_W-1:0]  tmr;
    logic              tmo;
    logic              found;
    logic [CH_W-1:0]   sel;

    assign tick = enable && (cnt == CNT_W'(PERIOD - 1));
    assign tmo  = (tmr == TMR_W'(TIMEOUT - 1));

    // Period counter: free-runs while enabled, parked at 0 otherwise.
    always_ff @(posedge clk) begin
        if (reset || !enable || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Lowest enabled channel at or above cur; ch_mask is taken live.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i] && (CUR_W'(i) >= cur)) begin
                found = 1'b1;
                sel   = CH_W'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next-state logic; an ack on the expiry cycle still counts as success.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (tick && (ch_mask != '0)) state_n = SELECT;
            SELECT:  state_n = found ? REQ : IDLE;
            REQ: begin
                if (adc_ack)
                    state_n = PUBLISH;
                else if (tmo)
                    state_n = SELECT;
            end
            PUBLISH: state_n = SELECT;
            default: state_n = IDLE;
        endcase
    end

    // Channel walk, wait timer and registered outputs (decoded from state_n
    // so req/busy line up with the state they describe).
    always_ff @(posedge clk) begin
        if (reset) begin
            cur          <= '0;
            tmr          <= '0;
            adc_req      <= 1'b0;
            adc_ch       <= '0;
            result_valid <= 1'b0;
            result_ch    <= '0;
            result_data  <= '0;
            LED          <= '0;
            timeout_err  <= '0;
            overrun      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            adc_req      <= (state_n == REQ);
            busy         <= (state_n != IDLE);
            result_valid <= 1'b0;
            if (tick && (state != IDLE))
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (state_n == SELECT)
                        cur <= '0;
                end
                SELECT: begin
                    tmr <= '0;
                    if (found) begin
                        cur    <= {1'b0, sel};
                        adc_ch <= sel;
                    end
                end
                REQ: begin
                    tmr <= tmr + 1'b1;
                    if (adc_ack) begin
                        result_valid            <= 1'b1;
                        result_ch               <= cur[CH_W-1:0];
                        result_data             <= adc_data;
                        LED[cur[CH_W-1:0]]      <= (adc_data < thresh);
                    end else if (tmo) begin
                        timeout_err[cur[CH_W-1:0]] <= 1'b1;
                        cur                        <= cur + 1'b1;
                    end
                end
                PUBLISH: cur <= cur + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sensor_sweep_scheduler.md
# sensor_sweep_scheduler

Periodic round-robin scheduler that shares the SoC's single sensor ADC between up to NUM_CH field-sensor channels (soil moisture, temperature, etc.). Every PERIOD cycles it sweeps the enabled channels in ascending order. For each channel it issues a req/ack conversion handshake to the ADC, publishes each result, and drives the board LED status bits. It sits between the processor-visible configuration (enable, mask, threshold) and the ADC front end.

## Interface
Parameters:
- NUM_CH, 4, number of sensor channels; also LED width
- DATA_W, 12, ADC sample width
- PERIOD, 1000, cycles between sweep starts; must be ≥ 2
- TIMEOUT, 64, max cycles to wait for adc_ack per channel; must be ≥ 1

Ports (CH_W = ceil(log2(NUM_CH)), minimum 1):
- clk, in, 1, single system clock, rising edge
- reset, in, 1, synchronous, active-high
- enable, in, 1, allows period ticks to start sweeps
- ch_mask, in, NUM_CH, bit i = 1 includes channel i in sweeps
- thresh, in, DATA_W, alarm threshold, unsigned
- adc_req, out, 1, conversion request to the ADC
- adc_ch, out, CH_W, channel selected for the conversion
- adc_ack, in, 1, ADC completion strobe; adc_data is valid in the same cycle
- adc_data, in, DATA_W, conversion result
- result_valid, out, 1, one-cycle pulse when a new sample is published
- result_ch, out, CH_W, channel of the published sample
- result_data, out, DATA_W, published sample
- LED, out, NUM_CH, bit i = 1 when channel i's last sample < thresh
- timeout_err, out, NUM_CH, sticky per-channel no-ack flag
- overrun, out, 1, sticky flag: a tick occurred while a sweep was in progress
- busy, out, 1, high while a sweep is in progress

## Operation
- Period counter:
  - Counts 0..PERIOD-1 while enable = 1, then wraps to 0.
  - "tick" is the cycle in which the count equals PERIOD-1.
  - While enable = 0 the counter is held at 0.
- FSM states and transitions:
  - IDLE → SELECT on a tick when ch_mask ≠ 0. A tick with ch_mask = 0 is ignored.
  - SELECT: finds the lowest enabled channel ≥ cur. The search starts at 0 at sweep start. ch_mask is re-sampled on every SELECT.
    - No remaining enabled channel → IDLE.
    - Otherwise cur is loaded → REQ.
  - REQ: adc_req = 1 and adc_ch = cur, both held stable.
    - adc_ack = 1 → capture adc_data → PUBLISH.
    - TIMEOUT cycles in REQ without an ack → set timeout_err[cur], cur = cur+1 → SELECT.
  - PUBLISH: result_valid = 1 for one cycle with result_ch = cur and result_data = the captured sample.
    - LED[cur] is updated to (captured < thresh), unsigned compare.
    - cur = cur+1 → SELECT.
    - If cur+1 = NUM_CH, the next SELECT returns to IDLE.
- busy = 1 in every state except IDLE.
- A tick outside IDLE sets overrun. No sweep is queued; the next sweep waits for the following tick.
- adc_ack outside REQ is ignored.
- An ack that arrives in the same cycle as the timeout expiry counts as success: the sample is published and no error is flagged.
- enable deasserted mid-sweep: the current sweep completes. No new sweep starts.
- timeout_err and overrun clear only on reset.
- LED bits of masked-off channels hold their last value.

## Timing
- Reset values: adc_req 0, adc_ch 0, result_valid 0, result_ch 0, result_data 0, LED 0, timeout_err 0, overrun 0, busy 0. FSM in IDLE, counters 0.
- Reset asserted mid-sweep aborts the sweep immediately; adc_req is 0 in the following cycle.
- Tick in cycle t → SELECT at t+1 → adc_req = 1 at t+2.
- Ack sampled in cycle a:
  - adc_req = 0 at a+1, with result_valid = 1 and LED updated in the same cycle a+1.
  - Next adc_req (if a channel remains) at a+3.
- Timeout: with adc_req rising at cycle r and no ack, adc_req = 0 at r+TIMEOUT and timeout_err is set in that same cycle.
- All outputs are registered.

## Test plan
- Reset, then enable = 1, ch_mask = 4'b1111, PERIOD = 20, ADC model acks 3 cycles after req with data = 100·(ch+1), thresh = 250 → four result_valid pulses (ch 0..3 with data 100, 200, 300, 400). LED = 4'b0011. First adc_req at cycle 21 after enable.
- ch_mask = 4'b1010 → only channels 1 and 3 are requested. LED bits 0 and 2 unchanged. busy drops after channel 3.
- ADC never acks channel 2, TIMEOUT = 8 → adc_req on ch 2 lasts exactly 8 cycles. timeout_err = 4'b0100. Channel 3 is still sampled. No result_valid for ch 2.
- Ack delay of 30 cycles per channel with PERIOD = 20 → overrun = 1. Sweeps start only on ticks seen in IDLE. No double request.
- Assert reset while adc_req = 1 on ch 1 → next cycle all outputs at their reset values. After release, no request until the first tick.
- ch_mask = 0, enable = 1 → no adc_req and busy stays 0 across 3 periods. Setting ch_mask = 4'b0001 → request on the next tick.
